mem_responder: RTL

- Memory-side responder for the CPU's load/store and fetch traffic, sitting between the CPU control path and on-chip word RAM.
- Accepts one request at a time over a valid/ready request channel, then inserts a programmable number of wait states.
- Performs the read or write, then holds a response on a valid/ready response channel until the CPU takes it.
- Out-of-range addresses get an error response and never touch the array.

---
 rtl/mem_responder_pkg.sv | 14 +
 rtl/mem_responder_ram.sv | 29 ++
 rtl/mem_responder.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder.
package mem_responder_pkg;

   localparam int MEM_ADDR_W = 16;
   localparam int MEM_DATA_W = 16;
   localparam int WAIT_W     = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_RESP = 2'b10
   } state_t;

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port synchronous word RAM; read data appears after the access edge.
module mem_responder_ram
   import mem_responder_pkg::*;
#(
   parameter int DEPTH_LOG2 = 8,
   parameter int DATA_W     = MEM_DATA_W
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [DATA_W-1:0]     wdata,
   output logic [DATA_W-1:0]     rdata
);

   logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

   // Array access; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[addr] <= wdata;
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accept one request, wait, access RAM, hold response.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a request; req_ready high
// BUSY    | request captured, counting wait states; access at count 0
// RESP    | response held on rsp_* until rsp_ready
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int ADDR_W      = MEM_ADDR_W,
   parameter int DATA_W      = MEM_DATA_W,
   parameter int DEPTH_LOG2  = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES);

   state_t              state;
   state_t              state_nxt;
   logic [WAIT_W-1:0]   cnt;
   logic                cap_write;
   logic [ADDR_W-1:0]   cap_addr;
   logic [DATA_W-1:0]   cap_wdata;
   logic                addr_oob;
   logic                accept;
   logic                access;
   logic                rsp_done;
   logic                rsp_err_q;
   logic                rsp_rd_q;
   logic                ram_en;
   logic [DATA_W-1:0]   ram_rdata;

   assign accept   = (state == ST_IDLE) && req_valid;
   assign access   = (state == ST_BUSY) && (cnt == '0);
   assign rsp_done = (state == ST_RESP) && rsp_ready;

   // Anything above the implemented depth is out of range; full-depth builds never err.
   generate
      if (DEPTH_LOG2 < ADDR_W) begin : g_oob
         assign addr_oob = |cap_addr[ADDR_W-1:DEPTH_LOG2];
      end else begin : g_no_oob
         assign addr_oob = 1'b0;
      end
   endgenerate

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; unknown encodings fall back to IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (req_valid)     state_nxt = ST_BUSY;
         ST_BUSY: if (cnt == '0)     state_nxt = ST_RESP;
         ST_RESP: if (rsp_ready)     state_nxt = ST_IDLE;
         default:                    state_nxt = ST_IDLE;
      endcase
   end

   // Wait-state down-counter, loaded on accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (accept) begin
         cnt <= WAIT_LOAD;
      end else if ((state == ST_BUSY) && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   // Request capture so later changes on req_* are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_write <= 1'b0;
         cap_addr  <= '0;
         cap_wdata <= '0;
      end else if (accept) begin
         cap_write <= req_write;
         cap_addr  <= req_addr;
         cap_wdata <= req_wdata;
      end
   end

   // Response flags set on the access edge and cleared on the handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_err_q <= 1'b0;
         rsp_rd_q  <= 1'b0;
      end else if (access) begin
         rsp_err_q <= addr_oob;
         rsp_rd_q  <= !cap_write && !addr_oob;
      end else if (rsp_done) begin
         rsp_err_q <= 1'b0;
         rsp_rd_q  <= 1'b0;
      end
   end

   // Out-of-range requests never enable the array, so writes cannot alias.
   assign ram_en = access && !addr_oob;

   mem_responder_ram #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .DATA_W     (DATA_W)
   ) u_ram (
      .clk   (clk),
      .en    (ram_en),
      .we    (cap_write),
      .addr  (cap_addr[DEPTH_LOG2-1:0]),
      .wdata (cap_wdata),
      .rdata (ram_rdata)
   );

   // The RAM output register holds until the next access, which cannot
   // happen before the handshake, so it serves as the held read data.
   assign req_ready = (state == ST_IDLE);
   assign rsp_valid = (state == ST_RESP);
   assign rsp_err   = rsp_valid && rsp_err_q;
   assign rsp_rdata = (rsp_valid && rsp_rd_q) ? ram_rdata : '0;

endmodule
